prbs_share_ctrl: RTL

Controller that time-shares one 7-bit PRBS7 `lfsr` instance (x^7+x^6+1) among `NUM_REQ` requesters. Each requester owns a saved LFSR context. On grant, the controller restores that context into the `lfsr`, streams `len` words with valid/ready backpressure, then saves the advanced state back. Each requester therefore sees its own uninterrupted PRBS7 stream, regardless of interleaving. It sits between traffic/BIST clients and the single shared `lfsr`.

---
 rtl/prbs_share_pkg.sv | 21 ++
 rtl/lfsr.sv | 33 +++
 rtl/prbs_share_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prbs_share_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prbs_share_pkg                                            |
// | Purpose  : Shared types and constants for the PRBS7 time-share ctrl. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package prbs_share_pkg;

  localparam int LFSR_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    SAVE = 2'd3
  } state_t;

  localparam logic [LFSR_W-1:0] ZERO_SEED = 7'b0;

endpackage
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lfsr                                                      |
// | Purpose  : PRBS7 (x^7+x^6+1) register with synchronous seed load.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module lfsr
  import prbs_share_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr_out
);

  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= seed;
    end else if (enable) begin
      r_q <= {r_q[LFSR_W-2:0], r_q[LFSR_W-1] ^ r_q[LFSR_W-2]};
    end
  end

  assign lfsr_out = r_q;

endmodule
`default_nettype wire

// File: rtl/prbs_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prbs_share_ctrl                                           |
// | Purpose  : Time-shares one PRBS7 lfsr among NUM_REQ requesters, each |
// |            with a saved context. Option: PRBS_SHARE_ZERO_GUARD_EN    |
// |            rejects zero seeds on the cfg port.                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module prbs_share_ctrl
  import prbs_share_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                LEN_W        = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 7'b1100111,
  localparam int               ID_W         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LFSR_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  input  logic                     cfg_we,
  input  logic [ID_W-1:0]          cfg_id,
  input  logic [LFSR_W-1:0]        cfg_seed,
  output logic                     cfg_err
);

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_last_id;
  logic [ID_W-1:0]   w_pick_id;
  logic [ID_W-1:0]   w_idx;
  logic              w_pick_valid;
  logic [LEN_W-1:0]  r_rem;
  logic [LFSR_W-1:0] r_ctx [NUM_REQ];
  logic [LFSR_W-1:0] w_lfsr_q;
  logic [NUM_REQ-1:0] w_elig;
  logic [LEN_W-1:0]  w_len [NUM_REQ];
  logic              w_accept;
  logic              w_cfg_zero;
  logic              w_cfg_rej;
  logic              w_cfg_ok;
  logic              r_cfg_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_len[gi]  = len[gi*LEN_W +: LEN_W];
      assign w_elig[gi] = req[gi] && (w_len[gi] != '0);
    end
  endgenerate

  // Scan from farthest to nearest so the first eligible index after r_last_id wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    w_idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last_id) + k) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_idx;
      end
    end
  end

  assign w_accept = (r_state == RUN) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (w_accept && (r_rem == LEN_W'(1))) w_next = SAVE;
      SAVE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id      <= '0;
      r_rem     <= '0;
      r_last_id <= ID_W'(NUM_REQ - 1);
    end else begin
      if ((r_state == IDLE) && w_pick_valid) begin
        r_id  <= w_pick_id;
        r_rem <= w_len[w_pick_id];
      end
      if (w_accept) r_rem <= r_rem - LEN_W'(1);
      if (r_state == SAVE) r_last_id <= r_id;
    end
  end

`ifdef PRBS_SHARE_ZERO_GUARD_EN
  assign w_cfg_zero = (cfg_seed == ZERO_SEED);
`else
  assign w_cfg_zero = 1'b0;
`endif

  // The active owner's context is off-limits until its advanced state is saved back.
  assign w_cfg_rej = cfg_we && (w_cfg_zero || ((r_state != IDLE) && (cfg_id == r_id)));
  assign w_cfg_ok  = cfg_we && !w_cfg_rej;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_ctx[i] <= DEFAULT_SEED;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_rej;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((r_state == SAVE) && (r_id == ID_W'(i))) begin
          r_ctx[i] <= w_lfsr_q;
        end else if (w_cfg_ok && (cfg_id == ID_W'(i))) begin
          r_ctx[i] <= cfg_seed;
        end
      end
    end
  end

  lfsr u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (r_state == LOAD),
    .enable   (w_accept),
    .seed     (r_ctx[r_id]),
    .lfsr_out (w_lfsr_q)
  );

  always_comb begin
    gnt = '0;
    if (r_state == LOAD) gnt[r_id] = 1'b1;
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == RUN);
  assign out_data  = w_lfsr_q;
  assign out_id    = r_id;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
